// File: rtl/dmu_pkg.sv
// Shared constants and helpers for the 4-way word dispatcher.
package dmu_pkg;

  localparam int unsigned NPORTS = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned WORD_W = 32;

  // Bit offset of channel ch inside a flattened NPORTS*width data bus.
  function automatic int unsigned slice_base(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/dmu_port_fifo.sv
// Per-channel FIFO for the dispatcher.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request and word (ignored when full)
//   pop        : read request (ignored when empty)
//   rdata      : head word, 0 when empty
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module dmu_port_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Explicit wrap so non-power-of-2 depths stay in 0..DEPTH-1.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible when count is nonzero.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmu4_dispatch.sv
// 1:4 word dispatcher: routes each input word to the channel named by in_sel,
// with an independent FIFO per channel so one stalled consumer does not block
// the others.
//   clk, reset : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_sel : producer handshake and routing select
//   out_valid/out_ready/out_data     : four consumer handshakes, channel i at [i*WIDTH +: WIDTH]
//   busy       : any channel holds data
module dmu4_dispatch
  import dmu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NPORTS-1:0]       out_valid,
  input  logic [NPORTS-1:0]       out_ready,
  output logic [NPORTS*WIDTH-1:0] out_data,
  output logic                    busy
);

  logic [CW-1:0]     count [NPORTS];
  logic [WIDTH-1:0]  rdata [NPORTS];
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;

  // Depends only on in_sel and registered counts: no ready-to-ready path.
  assign in_ready = !reset && (count[in_sel] < CW'(DEPTH));
  assign busy     = |out_valid;

  for (genvar g = 0; g < NPORTS; g++) begin : g_ch
    // The !full term is redundant with in_ready; it keeps the decode self-contained.
    assign push[g]      = in_valid && in_ready && (in_sel == SEL_W'(g)) && !full[g];
    assign pop[g]       = out_valid[g] && out_ready[g];
    assign out_valid[g] = !empty[g];
    assign out_data[slice_base(g, WIDTH) +: WIDTH] = rdata[g];

    dmu_port_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .wdata (in_data),
      .pop   (pop[g]),
      .rdata (rdata[g]),
      .count (count[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

endmodule

// File: tb/tb_dmu4_dispatch.sv
// Bench for dmu4_dispatch: a DEPTH=2 and a DEPTH=3 instance share all inputs and
// are each checked every cycle against a per-channel queue model.
module tb_dmu4_dispatch;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_ready;

  logic         in_ready2, in_ready3;
  logic [3:0]   out_valid2, out_valid3;
  logic [127:0] out_data2, out_data3;
  logic         busy2, busy3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef logic [31:0] wq_t[$];
  wq_t mq [8];  // index d*4+ch, d=0 -> DEPTH 2, d=1 -> DEPTH 3

  always #5 clk = ~clk;

  dmu4_dispatch #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .busy(busy2)
  );

  dmu4_dispatch #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid3),
    .out_ready(out_ready), .out_data(out_data3), .busy(busy3)
  );

  function automatic int depth_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare one instance's outputs with the model for the current inputs.
  task automatic compare(input int d, input string step);
    logic         e_rdy;
    logic [3:0]   e_vld;
    logic [127:0] e_dat;
    logic         o_rdy;
    logic [3:0]   o_vld;
    logic [127:0] o_dat;
    logic         o_busy;
    e_rdy = !reset && (mq[d*4 + int'(in_sel)].size() < depth_of(d));
    e_vld = '0;
    e_dat = '0;
    for (int c = 0; c < 4; c++) begin
      if (mq[d*4 + c].size() > 0) begin
        e_vld[c]        = 1'b1;
        e_dat[c*32 +: 32] = mq[d*4 + c][0];
      end
    end
    o_rdy  = (d == 0) ? in_ready2  : in_ready3;
    o_vld  = (d == 0) ? out_valid2 : out_valid3;
    o_dat  = (d == 0) ? out_data2  : out_data3;
    o_busy = (d == 0) ? busy2      : busy3;
    check($sformatf("%s/d%0d/in_ready", step, depth_of(d)), 128'(o_rdy), 128'(e_rdy));
    check($sformatf("%s/d%0d/out_valid", step, depth_of(d)), 128'(o_vld), 128'(e_vld));
    check($sformatf("%s/d%0d/out_data", step, depth_of(d)), o_dat, e_dat);
    check($sformatf("%s/d%0d/busy", step, depth_of(d)), 128'(o_busy), 128'(|e_vld));
  endtask

  // One clock: drive inputs after the falling edge, check before the rising
  // edge, then advance the model by what that rising edge does.
  task automatic cycle(input string step, input logic r, input logic v,
                       input logic [1:0] s, input logic [31:0] dat, input logic [3:0] ordy);
    logic acc [2];
    reset = r; in_valid = v; in_sel = s; in_data = dat; out_ready = ordy;
    #1;
    compare(0, step);
    compare(1, step);
    for (int d = 0; d < 2; d++) begin
      // A full channel refuses a push even if it pops this cycle.
      acc[d] = !r && v && (mq[d*4 + int'(s)].size() < depth_of(d));
    end
    if (r) begin
      for (int i = 0; i < 8; i++) mq[i].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++)
          if (ordy[c] && mq[d*4 + c].size() > 0) void'(mq[d*4 + c].pop_front());
        if (acc[d]) mq[d*4 + int'(s)].push_back(dat);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    @(negedge clk);

    // Reset held with a pending request.
    cycle("reset", 1, 1, 2'b01, 32'hDEAD_BEEF, 4'b0000);
    cycle("reset", 1, 1, 2'b01, 32'hDEAD_BEEF, 4'b0000);

    // Routing to every channel, consumers always ready.
    cycle("route", 0, 1, 2'b00, 32'hAAAA_0000, 4'b1111);
    cycle("route", 0, 1, 2'b01, 32'h1111_1111, 4'b1111);
    cycle("route", 0, 1, 2'b10, 32'h2222_2222, 4'b1111);
    cycle("route", 0, 1, 2'b11, 32'h3333_3333, 4'b1111);
    cycle("route", 0, 0, 2'b00, 32'h0,         4'b1111);
    cycle("route", 0, 0, 2'b00, 32'h0,         4'b1111);

    // Fill ch2 while its consumer stalls; other channels still flow.
    cycle("fill", 0, 1, 2'b10, 32'h1, 4'b1011);
    cycle("fill", 0, 1, 2'b10, 32'h2, 4'b1011);
    cycle("fill", 0, 1, 2'b10, 32'h3, 4'b1011);
    cycle("fill", 0, 1, 2'b00, 32'h5, 4'b1011);
    cycle("fill", 0, 1, 2'b10, 32'h3, 4'b1111);
    cycle("fill", 0, 1, 2'b10, 32'h3, 4'b1111);
    cycle("fill", 0, 1, 2'b10, 32'h3, 4'b1111);
    cycle("fill", 0, 0, 2'b10, 32'h0, 4'b1111);
    cycle("fill", 0, 0, 2'b10, 32'h0, 4'b1111);
    cycle("fill", 0, 0, 2'b10, 32'h0, 4'b1111);

    // Full channel popping refuses a push; then push+pop keeps count.
    cycle("fullpop", 0, 1, 2'b01, 32'hA, 4'b0000);
    cycle("fullpop", 0, 1, 2'b01, 32'hB, 4'b0000);
    cycle("fullpop", 0, 1, 2'b01, 32'hB, 4'b0000);
    cycle("fullpop", 0, 1, 2'b01, 32'hC, 4'b0010);
    cycle("fullpop", 0, 1, 2'b01, 32'hC, 4'b0010);
    cycle("fullpop", 0, 1, 2'b01, 32'hD, 4'b0000);
    cycle("fullpop", 0, 0, 2'b01, 32'h0, 4'b1111);
    cycle("fullpop", 0, 0, 2'b01, 32'h0, 4'b1111);
    cycle("fullpop", 0, 0, 2'b01, 32'h0, 4'b1111);

    // Pointer wrap on ch3: alternate push and pop of 0..9.
    for (int i = 0; i < 10; i++) begin
      cycle("wrap", 0, 1, 2'b11, 32'(i), 4'b0000);
      cycle("wrap", 0, 0, 2'b11, 32'h0,  4'b1000);
    end
    // Burst fill then drain on ch3 to wrap with multiple entries in flight.
    for (int i = 0; i < 8; i++) cycle("burst", 0, 1, 2'b11, 32'h100 + 32'(i), 4'b0000);
    for (int i = 0; i < 4; i++) cycle("burst", 0, 1, 2'b11, 32'h200 + 32'(i), 4'b1000);
    for (int i = 0; i < 4; i++) cycle("burst", 0, 0, 2'b11, 32'h0, 4'b1000);

    // Reset mid-run discards buffered words and ignores that cycle's traffic.
    cycle("midrst", 0, 1, 2'b00, 32'h0000_00A1, 4'b0000);
    cycle("midrst", 0, 1, 2'b00, 32'h0000_00A2, 4'b0000);
    cycle("midrst", 0, 1, 2'b11, 32'h0000_00B1, 4'b0000);
    cycle("midrst", 1, 1, 2'b00, 32'h0000_00C1, 4'b1111);
    cycle("midrst", 0, 0, 2'b00, 32'h0,         4'b1111);
    cycle("midrst", 0, 0, 2'b00, 32'h0,         4'b1111);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(63) == 0), 1'($urandom_range(1)),
            2'($urandom_range(3)), $urandom, 4'($urandom_range(15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
